// File: rtl/icache_pkg.sv
// icache_pkg: shared types, constants and field-width helpers for the instruction cache.
package icache_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, FILL} icache_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int BLOCK_W = 128;
   function automatic int idx_w(int sets);
      return $clog2(sets);
   endfunction
   function automatic int off_w(int words);
      return $clog2(words);
   endfunction
   function automatic int tag_w(int sets, int words);
      return 30 - $clog2(words) - $clog2(sets);
   endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: valid bits, tag and data storage with a combinational read port
// and one synchronous write port; valid bits also support a bulk clear.
module icache_array
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int IW = 3,
   parameter int TW = 25
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IW-1:0]      rd_idx_i,
   output logic               rd_valid_o,
   output logic [TW-1:0]      rd_tag_o,
   output logic [BLOCK_W-1:0] rd_data_o,
   input  logic               clr_i,
   input  logic               we_i,
   input  logic [IW-1:0]      wr_idx_i,
   input  logic [TW-1:0]      wr_tag_i,
   input  logic [BLOCK_W-1:0] wr_data_i
);
   logic [NUM_SETS-1:0] valid_q;
   logic [TW-1:0]       tag_q  [NUM_SETS];
   logic [BLOCK_W-1:0]  data_q [NUM_SETS];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) valid_q <= '0;
      else if (clr_i) valid_q <= '0;
      else if (we_i) valid_q[wr_idx_i] <= 1'b1;
   end
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache; same-cycle hits,
// misses stall fetch while a 16-byte block is fetched and filled.
module instr_cache
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        ADDRESS,
   input  logic               READ,
   input  logic               FLUSH,
   output logic [31:0]        INSTRUCTION,
   output logic               BUSYWAIT,
   output logic [27:0]        MEM_ADDRESS,
   output logic               MEM_READ,
   input  logic [BLOCK_W-1:0] MEM_READDATA,
   input  logic               MEM_BUSYWAIT
);
   localparam int OW = off_w(WORDS_PER_BLOCK);
   localparam int IW = idx_w(NUM_SETS);
   localparam int TW = tag_w(NUM_SETS, WORDS_PER_BLOCK);
   icache_state_t state_q, state_d;
   logic [TW-1:0] req_tag_q, req_tag_d, tag, rd_tag;
   logic [IW-1:0] req_idx_q, req_idx_d, idx;
   logic [BLOCK_W-1:0] fill_q, fill_d, rd_data;
   logic [OW-1:0] off;
   logic pend_q, pend_d, rd_valid, hit, busy, clr, we, unused_addr;
   assign off = ADDRESS[2 +: OW];
   assign idx = ADDRESS[2+OW +: IW];
   assign tag = ADDRESS[31 -: TW];
   assign unused_addr = ^ADDRESS[1:0];
   icache_array #(.NUM_SETS(NUM_SETS), .IW(IW), .TW(TW)) u_array (
      .clk_i(CLK), .rst_i(RESET), .rd_idx_i(idx), .rd_valid_o(rd_valid),
      .rd_tag_o(rd_tag), .rd_data_o(rd_data), .clr_i(clr), .we_i(we),
      .wr_idx_i(req_idx_q), .wr_tag_i(req_tag_q), .wr_data_i(fill_q)
   );
   // A FLUSH arriving together with a request must win, so it forces a miss.
   assign hit = READ & ~FLUSH & rd_valid & (rd_tag == tag) & (state_q == IDLE);
   assign INSTRUCTION = hit ? rd_data[{off, 5'b0} +: 32] : NOP_INSTR;
   assign BUSYWAIT = busy & ~RESET;
   assign MEM_ADDRESS = {req_tag_q, req_idx_q};
   always_comb begin
      state_d = state_q;
      req_tag_d = req_tag_q;
      req_idx_d = req_idx_q;
      fill_d = fill_q;
      pend_d = pend_q | FLUSH;
      busy = 1'b0;
      MEM_READ = 1'b0;
      clr = 1'b0;
      we = 1'b0;
      case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            clr = FLUSH | pend_q;
            if (READ & ~hit) begin
               busy = 1'b1;
               req_tag_d = tag;
               req_idx_d = idx;
               state_d = FETCH;
            end
         end
         FETCH: begin
            busy = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               fill_d = MEM_READDATA;
               state_d = FILL;
            end
         end
         FILL: begin
            busy = 1'b1;
            we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         req_tag_q <= '0;
         req_idx_q <= '0;
         fill_q <= '0;
         pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_tag_q <= req_tag_d;
         req_idx_q <= req_idx_d;
         fill_q <= fill_d;
         pend_q <= pend_d;
      end
   end
endmodule
